// File: rtl/amo_req_gen_cluster.sv
// amo_req_gen_cluster: initiator-side request generator for the cluster's
// bank-level atomic shim. Takes one 32-bit load/store/AMO at a time from a
// core port, packs it onto a DataWidth-wide TCDM master port and returns the
// selected 32-bit word through a buffered response handshake.
// Optional feature macro: AMO_REQ_TIMEOUT_EN (grant-wait timeout of
// TimeoutCycles cycles; REQ waits indefinitely when the macro is undefined).
module amo_req_gen_cluster #(
  parameter int unsigned AddrMemWidth  = 32,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_addr_i,
  input  logic [3:0]                req_amo_i,
  input  logic                      req_wen_i,
  input  logic [31:0]               req_wdata_i,
  input  logic [31:0]               req_cmp_i,
  input  logic [3:0]                req_be_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [31:0]               resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      out_req_o,
  input  logic                      out_gnt_i,
  output logic [AddrMemWidth-1:0]   out_add_o,
  output logic [3:0]                out_amo_o,
  output logic                      out_wen_o,
  output logic [DataWidth-1:0]      out_wdata_o,
  output logic [DataWidth/8-1:0]    out_be_o,
  input  logic [DataWidth-1:0]      out_rdata_i
);

  localparam int unsigned BeW = DataWidth / 8;

  typedef enum logic [1:0] {IDLE, REQ, DATA, RSP} state_e;

  state_e                  state_q, state_d;
  logic [AddrMemWidth-1:0] add_q, add_sel;
  logic [3:0]              amo_q;
  logic                    wen_q;
  logic [DataWidth-1:0]    wdata_q, wdata_sel;
  logic [BeW-1:0]          be_q, be_sel;
  logic                    hi_q, hi_sel;
  logic [31:0]             rdata_sel, resp_rdata_q;
  logic                    resp_err_q;
  logic                    illegal, is_amo, is_cas, timeout, accept;

  assign is_amo = (req_amo_i != 4'h0);
  assign is_cas = (req_amo_i == 4'hA);
  assign accept = (state_q == IDLE) && req_valid_i;

  // Lane packing depends on the bank width: 64-bit banks hold two 32-bit
  // words selected by address bit 2; 32-bit banks have no room for CAS.
  generate
    if (DataWidth == 64) begin : g_w64
      assign add_sel   = AddrMemWidth'(req_addr_i >> 3);
      assign hi_sel    = req_addr_i[2];
      assign wdata_sel = is_cas ? {req_wdata_i, req_cmp_i} : {req_wdata_i, req_wdata_i};
      assign be_sel    = is_amo ? (hi_sel ? 8'hF0 : 8'h0F)
                                : (hi_sel ? {req_be_i, 4'b0000} : {4'b0000, req_be_i});
      assign rdata_sel = hi_q ? out_rdata_i[63:32] : out_rdata_i[31:0];
      assign illegal   = (req_amo_i > 4'hA);
    end else begin : g_w32
      assign add_sel   = AddrMemWidth'(req_addr_i >> 2);
      assign hi_sel    = 1'b0;
      assign wdata_sel = req_wdata_i;
      assign be_sel    = is_amo ? 4'hF : req_be_i;
      assign rdata_sel = out_rdata_i;
      assign illegal   = (req_amo_i >= 4'hA);
    end
  endgenerate

`ifdef AMO_REQ_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] cnt_q;

  // Grant-wait counter: zero outside REQ, counts REQ cycles without grant.
  always_ff @(posedge clk_i) begin
    if (rst_i)                          cnt_q <= '0;
    else if (state_q != REQ)            cnt_q <= '0;
    else if (!out_gnt_i && !timeout)    cnt_q <= cnt_q + 1'b1;
  end

  // A grant in the final waiting cycle takes priority over the drop.
  assign timeout = (state_q == REQ) && !out_gnt_i &&
                   (cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic for the single-outstanding request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = illegal ? RSP : REQ;
      REQ: begin
        if (out_gnt_i)    state_d = DATA;
        else if (timeout) state_d = RSP;
      end
      DATA: state_d = RSP;
      RSP:  if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Bank-side request fields: latched once on acceptance, stable through REQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add_q   <= '0;
      amo_q   <= 4'h0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      hi_q    <= 1'b0;
    end else if (accept && !illegal) begin
      add_q   <= add_sel;
      amo_q   <= req_amo_i;
      wen_q   <= is_amo ? 1'b0 : req_wen_i;
      wdata_q <= wdata_sel;
      be_q    <= be_sel;
      hi_q    <= hi_sel;
    end
  end

  // Response buffer: bank data one cycle after grant, or an error word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else if (accept && illegal) begin
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b1;
    end else if (state_q == DATA) begin
      resp_rdata_q <= rdata_sel;
      resp_err_q   <= 1'b0;
    end else if (timeout) begin
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b1;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign out_req_o    = (state_q == REQ);
  assign resp_valid_o = (state_q == RSP);
  assign out_amo_o    = (state_q == REQ) ? amo_q : 4'h0;
  assign out_add_o    = add_q;
  assign out_wen_o    = wen_q;
  assign out_wdata_o  = wdata_q;
  assign out_be_o     = be_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_amo_req_gen_cluster.sv
// Self-checking bench for amo_req_gen_cluster (DataWidth=64, TimeoutCycles=4).
// Honours AMO_REQ_TIMEOUT_EN when the build defines it.
module tb_amo_req_gen_cluster;

  localparam int TO = 4;
  localparam logic [63:0] GARB = 64'hBADC0FFE_DEADBEEF;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_addr_i, req_wdata_i, req_cmp_i;
  logic [3:0]  req_amo_i, req_be_i;
  logic        req_wen_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        out_req_o, out_gnt_i, out_wen_o;
  logic [31:0] out_add_o;
  logic [3:0]  out_amo_o;
  logic [63:0] out_wdata_o, out_rdata_i;
  logic [7:0]  out_be_o;

  always #5 clk = ~clk;

  amo_req_gen_cluster #(.AddrMemWidth(32), .DataWidth(64), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_amo_i(req_amo_i), .req_wen_i(req_wen_i),
    .req_wdata_i(req_wdata_i), .req_cmp_i(req_cmp_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
    .out_amo_o(out_amo_o), .out_wen_o(out_wen_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_rdata_i(out_rdata_i)
  );

  typedef struct {
    logic [31:0] add;
    logic [3:0]  amo;
    logic        wen;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [63:0] rd64;
    logic [31:0] rd;
    logic        err;
    logic        illegal;
    logic        to;
    int          gnt_dly;
    int          rdy_dly;
    int          acc_n;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // What a transaction must look like on both ports, from the word/lane rules.
  function automatic exp_t model(input logic [31:0] addr, input logic [3:0] amo,
                                 input logic wen, input logic [31:0] wd,
                                 input logic [31:0] cmp, input logic [3:0] be,
                                 input logic [63:0] rd64, input int gd, input int rdy);
    exp_t e;
    int   lane;
    lane      = int'((addr >> 2) & 32'd1);
    e.add     = addr >> 3;
    e.illegal = (amo > 4'd10);
    e.amo     = amo;
    e.wen     = (amo == 4'd0) ? wen : 1'b0;
    e.wd      = (amo == 4'd10) ? {wd, cmp} : {wd, wd};
    e.be      = (amo == 4'd0) ? (8'(be) << (4 * lane)) : (8'h0F << (4 * lane));
    e.rd      = 32'(rd64 >> (32 * lane));
    e.err     = e.illegal;
    e.to      = 1'b0;
`ifdef AMO_REQ_TIMEOUT_EN
    if (!e.illegal && gd >= TO) e.to = 1'b1;
`endif
    if (e.illegal || e.to) begin
      e.rd  = 32'h0;
      e.err = 1'b1;
    end
    e.rd64    = rd64;
    e.gnt_dly = gd;
    e.rdy_dly = rdy;
    e.acc_n   = 0;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [3:0] amo, input logic wen,
                      input logic [31:0] wd, input logic [31:0] cmp, input logic [3:0] be,
                      input logic [63:0] rd64, input int gd, input int rdy);
    exp_t e;
    int   n;
    e = model(addr, amo, wen, wd, cmp, be, rd64, gd, rdy);
    req_addr_i = addr; req_amo_i = amo; req_wen_i = wen;
    req_wdata_i = wd; req_cmp_i = cmp; req_be_i = be;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 300) begin
      tick();
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", req_ready_o, 1'b1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    e.acc_n = ncyc;
    q.push_back(e);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready_o) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Bank/response responder and per-cycle comparison against the model.
  initial begin
    int   reqn, rspn, gnt_n;
    logic granted, gnt_prev, pop_pend;
    reqn = 0; rspn = 0; gnt_n = 0;
    granted = 1'b0; gnt_prev = 1'b0; pop_pend = 1'b0;
    out_gnt_i = 1'b0; resp_ready_i = 1'b0; out_rdata_i = GARB;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_i) begin
        q.delete();
        reqn = 0; rspn = 0; granted = 1'b0; gnt_prev = 1'b0; pop_pend = 1'b0;
        out_gnt_i = 1'b0; resp_ready_i = 1'b0; out_rdata_i = GARB;
        continue;
      end
      if (pop_pend) begin
        void'(q.pop_front());
        pop_pend = 1'b0; reqn = 0; rspn = 0; granted = 1'b0;
      end
      out_rdata_i = (gnt_prev && q.size() != 0) ? q[0].rd64 : GARB;
      gnt_prev = 1'b0;
      out_gnt_i = 1'b0;
      resp_ready_i = 1'b0;
      chk("req_ready", req_ready_o, q.size() == 0);
      if (out_req_o) begin
        if (q.size() == 0 || q[0].illegal || granted) begin
          chk("spurious_req", out_req_o, 1'b0);
        end else begin
          reqn++;
          if (reqn == 1) chk("acc_latency", 64'(ncyc - q[0].acc_n), 64'd1);
`ifdef AMO_REQ_TIMEOUT_EN
          if (reqn > TO) chk("timeout_drop", out_req_o, 1'b0);
`endif
          chk("out_add", out_add_o, q[0].add);
          chk("out_amo", out_amo_o, q[0].amo);
          chk("out_wen", out_wen_o, q[0].wen);
          chk("out_wdata", out_wdata_o, q[0].wd);
          chk("out_be", out_be_o, q[0].be);
          if (reqn > q[0].gnt_dly) begin
            out_gnt_i = 1'b1;
            granted = 1'b1;
            gnt_prev = 1'b1;
            gnt_n = ncyc;
          end
        end
      end else begin
        chk("amo_idle", out_amo_o, 4'h0);
      end
      if (resp_valid_o) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", resp_valid_o, 1'b0);
        end else begin
          rspn++;
          if (!q[0].illegal && !q[0].to) chk("rsp_after_gnt", granted, 1'b1);
          if (rspn == 1 && granted) chk("gnt_latency", 64'(ncyc - gnt_n), 64'd2);
          if (rspn == 1 && q[0].to) chk("timeout_cycles", 64'(reqn), 64'(TO));
          chk("resp_rdata", resp_rdata_o, q[0].rd);
          chk("resp_err", resp_err_o, q[0].err);
          if (rspn > q[0].rdy_dly) begin
            resp_ready_i = 1'b1;
            pop_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t p;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_amo_i = '0;
    req_wen_i = 1'b0; req_wdata_i = '0; req_cmp_i = '0; req_be_i = '0;

    // Pin the model itself with hand-computed vectors.
    p = model(32'h104, 4'h2, 1'b0, 32'd5, 32'd0, 4'h0, 64'h0000000A_00000000, 0, 0);
    chk("pin_add_add", p.add, 32'h20);
    chk("pin_add_be", p.be, 8'hF0);
    chk("pin_add_wdata", p.wd, 64'h00000005_00000005);
    chk("pin_add_rdata", p.rd, 32'hA);
    p = model(32'h100, 4'hA, 1'b0, 32'd9, 32'd7, 4'h0, 64'h0, 0, 0);
    chk("pin_cas_wdata", p.wd, 64'h00000009_00000007);
    chk("pin_cas_be", p.be, 8'h0F);
    p = model(32'h10C, 4'h0, 1'b1, 32'hCAFEBABE, 32'd0, 4'b0011, 64'h0, 0, 0);
    chk("pin_st_be", p.be, 8'h30);

    repeat (3) tick();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_resp_err", resp_err_o, 1'b0);
    chk("rst_out_req", out_req_o, 1'b0);
    chk("rst_out_amo", out_amo_o, 4'h0);
    chk("rst_out_wen", out_wen_o, 1'b0);
    chk("rst_out_add", out_add_o, 32'h0);
    chk("rst_out_wdata", out_wdata_o, 64'h0);
    chk("rst_out_be", out_be_o, 8'h0);
    chk("rst_resp_rdata", resp_rdata_o, 32'h0);
    rst_i = 1'b0;
    tick();

    // AMOAdd upper word, immediate grant.
    send(32'h104, 4'h2, 1'b0, 32'd5, 32'd0, 4'h0, 64'h0000000A_00000000, 0, 0);
    wait_idle();
    // CAS lower word.
    send(32'h100, 4'hA, 1'b0, 32'd9, 32'd7, 4'h0, 64'h11111111_22222222, 0, 0);
    wait_idle();
    // Plain store, grant delayed 3 cycles, response stalled 2 cycles.
    send(32'h10C, 4'h0, 1'b1, 32'hCAFEBABE, 32'd0, 4'b0011, 64'h33333333_44444444, 3, 2);
    wait_idle();
    // Plain load, lower word.
    send(32'h208, 4'h0, 1'b0, 32'h0, 32'd0, 4'hF, 64'h55555555_66666666, 0, 1);
    wait_idle();
    // Illegal AMO code.
    send(32'h40, 4'hC, 1'b0, 32'h1234, 32'd0, 4'h0, 64'h77777777_88888888, 0, 0);
    wait_idle();
    // Back-to-back AMOs, second grant withheld one cycle.
    send(32'h0, 4'h6, 1'b0, 32'hFFFF0000, 32'd0, 4'h0, 64'h9999AAAA_BBBBCCCC, 0, 0);
    send(32'h4, 4'h5, 1'b0, 32'h0F0F0F0F, 32'd0, 4'h0, 64'hDDDDEEEE_FFFF0001, 1, 0);
    wait_idle();
`ifdef AMO_REQ_TIMEOUT_EN
    // Grant never given: dropped with an error response.
    send(32'h300, 4'h1, 1'b0, 32'h5A5A5A5A, 32'd0, 4'h0, 64'h0, 1000, 0);
    wait_idle();
`endif
    // Reset asserted while waiting in REQ abandons the transaction.
    send(32'h408, 4'h3, 1'b0, 32'h00FF00FF, 32'd0, 4'h0, 64'h0, 1000, 0);
    tick();
    tick();
    chk("pre_rst_out_req", out_req_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("post_rst_out_req", out_req_o, 1'b0);
    chk("post_rst_resp_valid", resp_valid_o, 1'b0);
    chk("post_rst_req_ready", req_ready_o, 1'b1);
    repeat (6) tick();
    // One more transaction after the abandoned one.
    send(32'h50C, 4'h9, 1'b0, 32'h1, 32'd0, 4'h0, 64'h00000042_00000024, 0, 0);
    wait_idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amo_req_gen_cluster.md
Name: amo_req_gen_cluster

Overview:
- Initiator-side companion to the cluster's bank-level atomic shim.
- Accepts one 32-bit load, store or atomic request at a time from a core/LSU port. Packs it onto a DataWidth-wide TCDM bank port with a 4-bit AMO code, waits for grant, captures read data one cycle after grant and returns the selected 32-bit word to the requester through a buffered response handshake.
- Sits between the core's data port and the TCDM interconnect master port.

Parameters:
- AddrMemWidth, 32: bank word-address width driven on out_add_o.
- DataWidth, 64: bank data width; only 32 or 64 are legal.
- TimeoutCycles, 256: grant-wait limit, used only with the optional feature; must be >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted
- req_addr_i  in  32  byte address
- req_amo_i  in  4  0=none, 1=swap, 2=add, 3=and, 4=or, 5=xor, 6=max, 7=maxu, 8=min, 9=minu, A=CAS; B..F illegal
- req_wen_i  in  1  1=store, 0=load; ignored when req_amo_i != 0
- req_wdata_i  in  32  store data / AMO operand / CAS swap value
- req_cmp_i  in  32  CAS compare value
- req_be_i  in  4  byte enables for plain stores
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accepted
- resp_rdata_o  out  32  load data / old memory value
- resp_err_o  out  1  illegal op or timeout
- out_req_o  out  1  bank request
- out_gnt_i  in  1  bank grant
- out_add_o  out  AddrMemWidth  word address
- out_amo_o  out  4  AMO code
- out_wen_o  out  1  1=store
- out_wdata_o  out  DataWidth  write data
- out_be_o  out  DataWidth/8  byte enables
- out_rdata_i  in  DataWidth  read data, valid the cycle after grant

Behaviour:
- Reset (rst_i high at clk_i edge) forces:
  - state IDLE
  - req_ready_o=1, resp_valid_o=0, resp_err_o=0, out_req_o=0
  - out_amo_o=0, out_wen_o=0, out_add_o=0, out_wdata_o=0, out_be_o=0, resp_rdata_o=0
  - Reset mid-transaction abandons it with no response. A bank AMO already granted completes in the bank regardless.
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i, latch the request into the out_* registers and go to REQ. Illegal code B..F: no bank access; load the response register with rdata=0, err=1, and go to RSP.
  - REQ: out_req_o=1, req_ready_o=0, all out_* fields held stable. On out_gnt_i go to DATA; otherwise stay in REQ.
  - DATA: out_req_o=0. Capture the selected word of out_rdata_i into resp_rdata_o with err=0, then go to RSP.
  - RSP: resp_valid_o=1 with data held. On resp_ready_i go to IDLE.
- Latency: request acceptance to out_req_o is 1 cycle; grant to resp_valid_o is 2 cycles. Minimum spacing between accepted requests is 4 cycles.
- Word select, DataWidth=64:
  - out_add_o = req_addr_i[AddrMemWidth+2:3]; hi = req_addr_i[2].
  - Plain store: wdata replicated in both halves; be = hi ? {be,4'b0} : {4'b0,be}.
  - AMO other than CAS: wdata = {op,op}; be = hi ? 8'hF0 : 8'h0F.
  - CAS: wdata = {swap=req_wdata_i, cmp=req_cmp_i}; same be rule.
  - resp_rdata_o = hi ? rdata[63:32] : rdata[31:0], using the registered hi bit.
- Word select, DataWidth=32:
  - out_add_o = req_addr_i[AddrMemWidth+1:2].
  - CAS is treated as illegal (err=1, no bank access).
  - All other AMOs: be = 4'hF.
- The AMO code is driven only during REQ; plain loads and stores drive out_amo_o=0.
- out_wen_o=0 for all AMOs; the target side performs the write-back.
- A bank that withholds grant for one cycle after an AMO is absorbed by waiting in REQ.

Optional Feature:
- Macro: AMO_REQ_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to REQ and increments each REQ cycle without grant.
  - When it reaches TimeoutCycles-1 with out_gnt_i still low, the request is dropped: out_req_o falls next cycle and the FSM goes to RSP with rdata=0, err=1.
  - A grant arriving in that same cycle wins.
- Without the macro: no counter is built, REQ waits indefinitely, and timeout errors never occur (illegal codes still set err=1).

Test Plan:
- 64-bit AMOAdd: addr 0x104, operand 5, immediate grant, rdata 0x0000000A_00000000 -> out_amo_o=2, out_add_o=0x20, out_be_o=0xF0, out_wdata_o=0x00000005_00000005, out_wen_o=0; resp_rdata_o=0xA two cycles after grant.
- CAS lower word: addr 0x100, cmp 7, swap 9 -> out_wdata_o=0x00000009_00000007, out_be_o=0x0F, out_amo_o=0xA.
- Grant delayed 3 cycles, then resp_ready_i low 2 cycles -> out_* stable throughout REQ; resp_valid_o and resp_rdata_o held until accepted; req_ready_o low until return to IDLE.
- Illegal code 0xC -> no out_req_o pulse; resp_err_o=1, resp_rdata_o=0.
- Back-to-back AMOs with grant withheld one cycle after the first -> second request waits in REQ; both responses return in order.
- AMO_REQ_TIMEOUT_EN, TimeoutCycles=4, grant never given -> err response after 4 REQ cycles. Reset asserted in REQ -> out_req_o=0 next cycle and no response.
